hex_display_sched: RTL and testbench
====================================

Name: hex_display_sched

Overview:
- Sequencer that shares one 7-segment hex decoder across the four DE1 digits HEX3..HEX0.
- Accepts a 16-bit value through a ready/load handshake.
- Decodes one nibble per cycle, most significant first, into per-digit segment registers.
- Adds optional leading-zero blanking and per-digit blinking.
- Sits between counter/status logic and the board's HEX pins.

Parameters:
- BLINK_DIV, 12_500_000: CLOCK_50 cycles per blink phase (4 Hz toggle, 2 Hz blink). Must be >= 2.

Ports:
- CLOCK_50  in  1  system clock. reset, synchronous, active-high; clock CLOCK_50.
- reset  in  1  synchronous, active-high reset.
- load  in  1  request to display `value`; accepted only when ready=1.
- value  in  16  four hex nibbles; [15:12]→HEX3 … [3:0]→HEX0.
- lz_blank  in  1  blank leading zeros; sampled at acceptance.
- blink_mask  in  4  bit n blinks HEXn; sampled at acceptance.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when all four digits have been updated.
- HEX0..HEX3  out  7 each  active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset (any cycle, including mid-decode):
  - state→IDLE; digit registers→7'h7F (blank); ready=1; done=0.
  - Captured value/flags/mask cleared; prescaler=0; blink phase=0.
- States: IDLE → DECODE → DONE → IDLE.
- IDLE:
  - ready=1.
  - On load=1, capture value, lz_blank and blink_mask; set idx=3; go to DECODE.
  - This clock edge is T0.
- DECODE:
  - ready=0; idx counts 3,2,1,0.
  - At edge T1 the HEX3 register is written, at T2 HEX2, at T3 HEX1, at T4 HEX0.
  - After T4, go to DONE.
- DONE:
  - done=1 for exactly one cycle (the cycle after T4); ready=0.
  - Next edge (T5) → IDLE, so ready=1 from T5.
- load while ready=0 is ignored: no capture and no queuing. The captured inputs stay fixed for the whole operation.
- Shared decoder (one instance, nibble selected by idx). Codes in hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blank (captured lz_blank=1):
  - A digit is written as 7F if its nibble and all higher nibbles are 0 and idx≠0.
  - A "seen nonzero" flag tracks this; it is cleared at T0.
  - Digit 0 is never blanked, so value 0 shows "0".
- Blink:
  - Free-running prescaler counts 0..BLINK_DIV-1 and wraps; blink phase toggles on each wrap.
  - Prescaler and phase are independent of the handshake.
  - HEXn = (phase & mask_q[n]) ? 7'h7F : digit_reg[n], driven only from registers.
  - A digit blanked by leading-zero blanking stays 7F in both phases.
- Digit registers hold their values between operations; a new load overwrites all four.
- Arithmetic widths:
  - idx is 2 bits; decrementing wraps, but the FSM leaves DECODE at idx=0.
  - Prescaler width is clog2(BLINK_DIV).

Test Plan (BLINK_DIV=4 on the bench):
- Reset for 2 cycles → HEX0..3=7F, ready=1, done=0, held until load.
- load, value=16'h1234, lz=0, mask=0 → expected sequence:
  - ready=0 after T0.
  - HEX3=79 after T1, HEX2=24 after T2, HEX1=30 after T3, HEX0=19 after T4.
  - done=1 for one cycle only; ready=1 after T5.
- value=16'h0070, lz=1 → HEX3=7F, HEX2=7F, HEX1=78, HEX0=40.
- value=16'h0000, lz=1 → HEX3..1=7F, HEX0=40.
- value=16'h0000, lz=0 → all four digits=40.
- load value=16'hABCD, then load value=16'h5555 at T2 → second load ignored; final HEX3..0 = 08, 03, 46, 21.
- value=16'h0008, lz=0, mask=4'b0001, held idle → HEX0 alternates 00 / 7F every 4 cycles; HEX3..1 steady at 40.
- reset asserted at T2 of a decode → next cycle all HEX=7F, ready=1, no done pulse.

Source files
------------

// File: rtl/hex_display_sched.sv
// Drives HEX3..HEX0 from one shared 7-segment decoder, one nibble per cycle, MSB first.
// Supports leading-zero blanking and per-digit blinking from a free-running prescaler.
module hex_display_sched #(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lz_blank,
  input  logic [3:0]  blink_mask,
  output logic        ready,
  output logic        done,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [1:0]  fsm_state
);

  localparam int PW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Handshake: a transfer happens on a clock edge where ready=1 and load=1;
  // load while ready=0 is dropped, never queued.
  state_t         state_q, state_d;
  logic [1:0]     idx_q;
  logic [15:0]    value_q;
  logic           lz_q;
  logic [3:0]     mask_q;
  logic           seen_q;
  logic [6:0]     digit_q [4];
  logic [PW-1:0]  presc_q;
  logic           phase_q;

  logic           accept;
  logic [3:0]     nibble;
  logic [6:0]     seg;
  logic           blank_lz;

  assign accept    = (state_q == S_IDLE) && load;
  assign fsm_state = state_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (load) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (idx_q == 2'd0) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    nibble = 4'h0;
    case (idx_q)
      2'd3:    nibble = value_q[15:12];
      2'd2:    nibble = value_q[11:8];
      2'd1:    nibble = value_q[7:4];
      default: nibble = value_q[3:0];
    endcase
  end

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

  // Digit 0 is never blanked so an all-zero value still shows "0".
  assign blank_lz = lz_q && !seen_q && (nibble == 4'h0) && (idx_q != 2'd0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      idx_q   <= 2'd0;
      value_q <= 16'h0000;
      lz_q    <= 1'b0;
      mask_q  <= 4'h0;
      seen_q  <= 1'b0;
      for (int i = 0; i < 4; i++) digit_q[i] <= 7'h7F;
    end else if (accept) begin
      idx_q   <= 2'd3;
      value_q <= value;
      lz_q    <= lz_blank;
      mask_q  <= blink_mask;
      seen_q  <= 1'b0;
    end else if (state_q == S_DECODE) begin
      digit_q[idx_q] <= blank_lz ? 7'h7F : seg;
      seen_q         <= seen_q | (nibble != 4'h0);
      idx_q          <= idx_q - 2'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_q <= '0;
      phase_q <= 1'b0;
    end else if (presc_q == PRESC_MAX) begin
      presc_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign HEX0 = (phase_q & mask_q[0]) ? 7'h7F : digit_q[0];
  assign HEX1 = (phase_q & mask_q[1]) ? 7'h7F : digit_q[1];
  assign HEX2 = (phase_q & mask_q[2]) ? 7'h7F : digit_q[2];
  assign HEX3 = (phase_q & mask_q[3]) ? 7'h7F : digit_q[3];

endmodule

// File: tb/tb_hex_display_sched.sv
// Bench for hex_display_sched: vector table, hand-written corner sequences and random
// loads checked against a digit/blink model derived from the display rules.
module tb_hex_display_sched;

  localparam int BLINK_DIV = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        lz_blank;
  logic [3:0]  blink_mask;
  logic        ready, done;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic [1:0]  fsm_state;

  hex_display_sched #(.BLINK_DIV(BLINK_DIV)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .load(load), .value(value),
    .lz_blank(lz_blank), .blink_mask(blink_mask), .ready(ready), .done(done),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .fsm_state(fsm_state)
  );

  // clock / reset
  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int failures = 0;

  // Edges seen since reset released: blink phase = floor(k / BLINK_DIV) mod 2.
  int edges_k = 0;
  always @(posedge CLOCK_50) begin
    if (reset) edges_k <= 0;
    else       edges_k <= edges_k + 1;
  end

  // reference model
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] disp_m [4];
  logic [3:0] mask_m;

  function automatic logic [6:0] model_digit(logic [15:0] v, logic lz, int d);
    logic [15:0] upper;
    logic [15:0] nib;
    upper = v >> (4 * d);
    nib   = upper & 16'h000F;
    if (lz && d != 0 && upper == 16'h0000) return 7'h7F;
    return seg_tab[nib[3:0]];
  endfunction

  function automatic logic [6:0] model_hex(int n);
    bit ph;
    ph = ((edges_k / BLINK_DIV) % 2) == 1;
    return (ph && mask_m[n]) ? 7'h7F : disp_m[n];
  endfunction

  function automatic logic [6:0] dut_hex(int n);
    case (n)
      0: return HEX0;
      1: return HEX1;
      2: return HEX2;
      default: return HEX3;
    endcase
  endfunction

  // scoreboard
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_hex(string tag);
    for (int n = 0; n < 4; n++)
      check($sformatf("%s HEX%0d", tag, n), 16'(dut_hex(n)), 16'(model_hex(n)));
  endtask

  // driver tasks
  task automatic do_reset(int cycles);
    @(negedge CLOCK_50);
    reset = 1'b1;
    load  = 1'b0;
    repeat (cycles) @(negedge CLOCK_50);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) disp_m[n] = 7'h7F;
    mask_m = 4'h0;
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge after T5.
  task automatic run_op(logic [15:0] v, logic lz, logic [3:0] m, bit noise);
    check("pre-load ready", 16'(ready), 16'd1);
    load = 1'b1; value = v; lz_blank = lz; blink_mask = m;
    @(negedge CLOCK_50);                         // after T0
    mask_m = m;
    load = noise; value = 16'($urandom); lz_blank = 1'($urandom); blink_mask = 4'($urandom);
    check("T0 ready", 16'(ready), 16'd0);
    check("T0 done", 16'(done), 16'd0);
    for (int d = 3; d >= 0; d--) begin
      @(negedge CLOCK_50);                       // after T(4-d)
      disp_m[d] = model_digit(v, lz, d);
      load = noise; value = 16'($urandom); lz_blank = 1'($urandom); blink_mask = 4'($urandom);
      check_all_hex($sformatf("digit%0d", d));
      check($sformatf("ready busy d%0d", d), 16'(ready), 16'd0);
      check($sformatf("done d%0d", d), 16'(done), (d == 0) ? 16'd1 : 16'd0);
    end
    @(negedge CLOCK_50);                         // after T5
    load = 1'b0;
    check("T5 ready", 16'(ready), 16'd1);
    check("T5 done", 16'(done), 16'd0);
    check_all_hex("T5");
  endtask

  typedef struct {
    logic [15:0] v;
    logic        lz;
    logic [6:0]  exp_hex [4];   // HEX0..HEX3
  } vec_t;

  vec_t vecs [7];
  bit seen_on, seen_off;

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; lz_blank = 1'b0; blink_mask = '0;
    vecs[0] = '{16'h1234, 1'b0, '{7'h19, 7'h30, 7'h24, 7'h79}};
    vecs[1] = '{16'h0070, 1'b1, '{7'h40, 7'h78, 7'h7F, 7'h7F}};
    vecs[2] = '{16'h0000, 1'b1, '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
    vecs[3] = '{16'h0000, 1'b0, '{7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[4] = '{16'hF0A5, 1'b1, '{7'h12, 7'h08, 7'h40, 7'h0E}};
    vecs[5] = '{16'h000F, 1'b1, '{7'h0E, 7'h7F, 7'h7F, 7'h7F}};
    vecs[6] = '{16'h0100, 1'b1, '{7'h40, 7'h40, 7'h79, 7'h7F}};

    // Reset state, held while idle.
    do_reset(2);
    for (int c = 0; c < 3; c++) begin
      for (int n = 0; n < 4; n++) check($sformatf("reset HEX%0d", n), 16'(dut_hex(n)), 16'h7F);
      check("reset ready", 16'(ready), 16'd1);
      check("reset done", 16'(done), 16'd0);
      @(negedge CLOCK_50);
    end

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].v, vecs[i].lz, 4'h0, 1'b0);
      for (int n = 0; n < 4; n++)
        check($sformatf("vec%0d HEX%0d", i, n), 16'(dut_hex(n)), 16'(vecs[i].exp_hex[n]));
    end

    // Loads during busy cycles must be ignored.
    run_op(16'hABCD, 1'b0, 4'h0, 1'b1);
    check("abcd HEX3", 16'(HEX3), 16'h08);
    check("abcd HEX2", 16'(HEX2), 16'h03);
    check("abcd HEX1", 16'(HEX1), 16'h46);
    check("abcd HEX0", 16'(HEX0), 16'h21);

    // Blinking digit 0 while idle.
    run_op(16'h0008, 1'b0, 4'b0001, 1'b0);
    seen_on = 0; seen_off = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLOCK_50);
      check_all_hex("blink");
      check("blink HEX3", 16'(HEX3), 16'h40);
      if (HEX0 == 7'h00) seen_on = 1;
      if (HEX0 == 7'h7F) seen_off = 1;
    end
    check("blink both phases", 16'({seen_on, seen_off}), 16'b11);

    // Reset in the middle of a decode.
    load = 1'b1; value = 16'h9876; lz_blank = 1'b0; blink_mask = 4'h0;
    @(negedge CLOCK_50);                         // after T0
    load = 1'b0;
    @(negedge CLOCK_50);                         // after T1
    reset = 1'b1;
    @(negedge CLOCK_50);                         // after T2 (reset)
    reset = 1'b0;
    for (int n = 0; n < 4; n++) disp_m[n] = 7'h7F;
    mask_m = 4'h0;
    for (int c = 0; c < 5; c++) begin
      for (int n = 0; n < 4; n++) check($sformatf("midrst HEX%0d", n), 16'(dut_hex(n)), 16'h7F);
      check("midrst ready", 16'(ready), 16'd1);
      check("midrst done", 16'(done), 16'd0);
      @(negedge CLOCK_50);
    end

    // Random operations against the model, with and without busy-time loads.
    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(negedge CLOCK_50);
        check_all_hex("rand idle");
      end
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
